// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller slice: FSM state encoding and
// the address-width helper used to size parameters.
package mem_ctrl_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  // Smallest width (at least 1) that can index 'value' distinct words.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/mem_dp_array.sv
// Simple dual-port word array with a registered, read-first read port.
// Out-of-range reads return zero but are still qualified as valid.
module mem_dp_array #(
  parameter int C_WORDSIZE = 8,
  parameter int C_MEMSIZE  = 4096,
  parameter int C_ADDRSIZE = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [C_ADDRSIZE-1:0] wr_addr,
  input  logic [C_WORDSIZE-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [C_ADDRSIZE-1:0] rd_addr,
  output logic [C_WORDSIZE-1:0] rd_data,
  output logic                  rd_valid
);

  logic [C_WORDSIZE-1:0] mem [C_MEMSIZE];
  logic                  rd_in_range;

  assign rd_in_range = (32'(rd_addr) < C_MEMSIZE);

  // Storage is deliberately left out of reset so a reset only aborts control.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else if (rd_en) begin
      rd_data  <= rd_in_range ? mem[rd_addr] : '0;
      rd_valid <= 1'b1;
    end else begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates host writes/reads against a sequential clear
// sweep that fills every word with C_INITVAL, one word per cycle.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int                    C_WORDSIZE = 8,
  parameter int                    C_MEMSIZE  = 4096,
  parameter int                    C_ADDRSIZE = clog2(C_MEMSIZE),
  parameter logic [C_WORDSIZE-1:0] C_INITVAL  = '0
) (
  input  logic                  I_clk,
  input  logic                  I_rst,
  input  logic                  I_wr_en,
  input  logic [C_ADDRSIZE-1:0] I_wr_addr,
  input  logic [C_WORDSIZE-1:0] I_wr_data,
  input  logic                  I_rd_en,
  input  logic [C_ADDRSIZE-1:0] I_rd_addr,
  output logic [C_WORDSIZE-1:0] O_rd_data,
  output logic                  O_rd_valid,
  input  logic                  I_clr,
  output logic                  O_busy,
  output logic                  O_clr_done
);

  localparam logic [C_ADDRSIZE-1:0] LAST_ADDR = C_ADDRSIZE'(C_MEMSIZE - 1);
  localparam logic [C_ADDRSIZE-1:0] ADDR_ONE  = 1;

  state_e                  state_q, state_d;
  logic [C_ADDRSIZE-1:0]   clr_addr_q, clr_addr_d;
  logic                    clr_done_q, clr_done_d;
  logic                    wr_in_range;
  logic                    arr_wr_en;
  logic [C_ADDRSIZE-1:0]   arr_wr_addr;
  logic [C_WORDSIZE-1:0]   arr_wr_data;
  logic                    arr_rd_en;

  assign wr_in_range = (32'(I_wr_addr) < C_MEMSIZE);

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q    <= ST_IDLE;
      clr_addr_q <= '0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      clr_done_q <= clr_done_d;
    end
  end

  // The sweep owns the write port while clearing; host traffic is ignored.
  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    clr_done_d  = 1'b0;
    arr_wr_en   = 1'b0;
    arr_wr_addr = I_wr_addr;
    arr_wr_data = I_wr_data;
    arr_rd_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        arr_rd_en = I_rd_en;
        if (I_clr) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
        end else begin
          arr_wr_en = I_wr_en & wr_in_range;
        end
      end
      ST_CLEAR: begin
        arr_wr_en   = 1'b1;
        arr_wr_addr = clr_addr_q;
        arr_wr_data = C_INITVAL;
        if (clr_addr_q == LAST_ADDR) begin
          state_d    = ST_IDLE;
          clr_addr_d = '0;
          clr_done_d = 1'b1;
        end else begin
          clr_addr_d = clr_addr_q + ADDR_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign O_busy     = (state_q == ST_CLEAR);
  assign O_clr_done = clr_done_q;

  mem_dp_array #(
    .C_WORDSIZE (C_WORDSIZE),
    .C_MEMSIZE  (C_MEMSIZE),
    .C_ADDRSIZE (C_ADDRSIZE)
  ) u_array (
    .clk      (I_clk),
    .rst      (I_rst),
    .wr_en    (arr_wr_en),
    .wr_addr  (arr_wr_addr),
    .wr_data  (arr_wr_data),
    .rd_en    (arr_rd_en),
    .rd_addr  (I_rd_addr),
    .rd_data  (O_rd_data),
    .rd_valid (O_rd_valid)
  );

endmodule
